// File: rtl/adc_decimator_if.sv
// Sample-in / decimated-word-out bundle for adc_decimator.
// The master is the side feeding samples and consuming results; the slave is the decimator.
interface adc_decimator_if #(
  parameter int DW      = 8,
  parameter int FIFO_AW = 2
);
  logic signed [DW-1:0] in_data;
  logic                 in_valid;
  logic signed [DW-1:0] out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [FIFO_AW:0]     fill_level;
  logic                 overflow;

  modport master (
    output in_data, in_valid, out_ready,
    input  out_data, out_valid, fill_level, overflow
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output out_data, out_valid, fill_level, overflow
  );
endinterface

// File: rtl/adc_decimator.sv
// Accumulate-and-dump decimator (average of 2^DECIM_LOG2 samples) feeding a small result FIFO.
// Define DECIM_ROUND_EN for round-half-up averaging; otherwise the average is floor-truncated.
module adc_decimator #(
  parameter int DW         = 8,
  parameter int DECIM_LOG2 = 2,
  parameter int FIFO_AW    = 2
) (
  input  logic            CLK_250M,
  input  logic            RST_n,
  adc_decimator_if.slave  bus
);
  localparam int AW    = DW + DECIM_LOG2;
  localparam int DEPTH = 1 << FIFO_AW;

  logic signed [AW-1:0]   acc;
  logic signed [AW-1:0]   sum;
  logic [DECIM_LOG2-1:0]  phase;
  logic signed [DW-1:0]   result;
  logic                   last_smp;

  logic signed [DW-1:0]   mem [DEPTH];
  logic [FIFO_AW-1:0]     wr_ptr;
  logic [FIFO_AW-1:0]     rd_ptr;
  logic [FIFO_AW:0]       count;
  logic                   empty;
  logic                   full;
  logic                   pop;
  logic                   push_ok;
  logic                   drop;

  assign sum      = acc + {{DECIM_LOG2{bus.in_data[DW-1]}}, bus.in_data};
  assign last_smp = bus.in_valid && (&phase);

`ifdef DECIM_ROUND_EN
  // One extra bit keeps the rounding offset from wrapping a near-full-scale sum.
  logic signed [AW:0] sum_rnd;
  assign sum_rnd = {sum[AW-1], sum} + (AW+1)'(1 << (DECIM_LOG2 - 1));
  assign result  = DW'(sum_rnd >>> DECIM_LOG2);
`else
  assign result  = DW'(sum >>> DECIM_LOG2);
`endif

  assign empty   = (count == '0);
  assign full    = (count == (FIFO_AW+1)'(DEPTH));
  assign pop     = !empty && bus.out_ready;
  // A pop on the same edge frees the slot, so a push into a full FIFO still lands.
  assign push_ok = last_smp && (!full || pop);
  assign drop    = last_smp && full && !pop;

  always_ff @(posedge CLK_250M) begin
    if (!RST_n) begin
      acc          <= '0;
      phase        <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      bus.overflow <= 1'b0;
    end else begin
      if (bus.in_valid) begin
        if (last_smp) begin
          acc   <= '0;
          phase <= '0;
        end else begin
          acc   <= sum;
          phase <= phase + 1'b1;
        end
      end
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop) bus.overflow <= 1'b1;
    end
  end

  always_ff @(posedge CLK_250M) begin
    if (push_ok) mem[wr_ptr] <= result;
  end

  assign bus.out_valid  = !empty;
  assign bus.out_data   = empty ? '0 : mem[rd_ptr];
  assign bus.fill_level = count;
endmodule

// File: tb/tb_adc_decimator.sv
// Scoreboard bench for adc_decimator: expected averages are queued as samples are driven
// and compared whenever the DUT hands a word over. Honours DECIM_ROUND_EN like the DUT.
module tb_adc_decimator;
  localparam int DW         = 8;
  localparam int DECIM_LOG2 = 2;
  localparam int FIFO_AW    = 2;
  localparam int DEPTH      = 1 << FIFO_AW;
  localparam int NBLK       = 1 << DECIM_LOG2;

  logic clk = 1'b0;
  logic rst_n;
  always #2 clk = ~clk;

  adc_decimator_if #(.DW(DW), .FIFO_AW(FIFO_AW)) bus ();

  adc_decimator #(.DW(DW), .DECIM_LOG2(DECIM_LOG2), .FIFO_AW(FIFO_AW)) dut (
    .CLK_250M (clk),
    .RST_n    (rst_n),
    .bus      (bus)
  );

  int checks = 0;
  int errors = 0;

  logic signed [DW-1:0] sb_q [$];
  logic signed [DW-1:0] mon_exp;
  int   m_phase;
  int   m_sum;
  logic exp_ovf;

  function automatic logic signed [DW-1:0] model_result(input int s);
`ifdef DECIM_ROUND_EN
    return DW'((s + (1 << (DECIM_LOG2 - 1))) >>> DECIM_LOG2);
`else
    return DW'(s >>> DECIM_LOG2);
`endif
  endfunction

  task automatic model_reset();
    sb_q.delete();
    m_phase = 0;
    m_sum   = 0;
    exp_ovf = 1'b0;
  endtask

  // Inputs change 1 time unit after a rising edge; the sample is consumed at the next edge.
  task automatic drive(input logic signed [DW-1:0] d, input logic v, input logic rdy);
    @(posedge clk);
    #1;
    bus.in_data   = d;
    bus.in_valid  = v;
    bus.out_ready = rdy;
    if (v) begin
      m_sum += int'(d);
      if (m_phase == NBLK - 1) begin
        if (sb_q.size() == DEPTH && !rdy) exp_ovf = 1'b1;
        else                              sb_q.push_back(model_result(m_sum));
        m_sum   = 0;
        m_phase = 0;
      end else begin
        m_phase++;
      end
    end
  endtask

  task automatic idle(input int n, input logic rdy);
    repeat (n) drive('0, 1'b0, rdy);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 40 && sb_q.size() != 0; i++) drive('0, 1'b0, 1'b1);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain_timeout: %0d words still expected", name, sb_q.size());
    end
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_drained_valid: out_valid=%b expected 0", name, bus.out_valid);
    end
    checks++;
    if (bus.fill_level !== '0) begin
      errors++;
      $display("FAIL %s_drained_fill: fill_level=%0d expected 0", name, bus.fill_level);
    end
  endtask

  // Pop happens at the next rising edge whenever valid and ready are both high here.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL sb_underflow: out_valid=1 out_data=%0d with nothing expected", bus.out_data);
      end else begin
        mon_exp = sb_q.pop_front();
        if (bus.out_data !== mon_exp) begin
          errors++;
          $display("FAIL sb_data: out_data=%0d expected %0d", bus.out_data, mon_exp);
        end
      end
    end
  end

  task automatic check_idle_outputs(input string name);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== '0 || bus.fill_level !== '0 || bus.overflow !== 1'b0) begin
      errors++;
      $display("FAIL %s: valid=%b data=%0d fill=%0d ovf=%b expected all 0", name,
               bus.out_valid, bus.out_data, bus.fill_level, bus.overflow);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset_initial");
    rst_n = 1'b1;
    model_reset();
    drive(8'sd50, 1'b1, 1'b0);
    drive(8'sd50, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    check_idle_outputs("reset_mid_block");
    rst_n = 1'b1;
    model_reset();
    repeat (4) drive(8'sd8, 1'b1, 1'b0);
    idle(1, 1'b0);
    checks++;
    if (bus.fill_level !== 3'd1 || bus.out_data !== 8'sd8) begin
      errors++;
      $display("FAIL reset_fresh_block: fill=%0d data=%0d expected fill 1 data 8",
               bus.fill_level, bus.out_data);
    end
    drain("reset");
  endtask

  task automatic run_block(input logic signed [DW-1:0] d0, d1, d2, d3,
                           input logic signed [DW-1:0] expv, input string name);
    drive(d0, 1'b1, 1'b0);
    drive(d1, 1'b1, 1'b0);
    drive(d2, 1'b1, 1'b0);
    drive(d3, 1'b1, 1'b0);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_early_valid: out_valid=%b expected 0", name, bus.out_valid);
    end
    idle(1, 1'b0);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== expv) begin
      errors++;
      $display("FAIL %s_result: valid=%b data=%0d expected valid 1 data %0d",
               name, bus.out_valid, bus.out_data, expv);
    end
    drain(name);
  endtask

  task automatic test_average();
`ifdef DECIM_ROUND_EN
    run_block(8'sd1, 8'sd1, 8'sd2, 8'sd2, 8'sd2, "avg_pos");
    run_block(-8'sd1, -8'sd1, -8'sd1, -8'sd2, -8'sd1, "avg_neg");
`else
    run_block(8'sd1, 8'sd1, 8'sd2, 8'sd2, 8'sd1, "avg_pos");
    run_block(-8'sd1, -8'sd1, -8'sd1, -8'sd2, -8'sd2, "avg_neg");
`endif
    run_block(8'sd127, 8'sd127, 8'sd127, 8'sd127, 8'sd127, "avg_max");
    run_block(-8'sd128, -8'sd128, -8'sd128, -8'sd128, -8'sd128, "avg_min");
  endtask

  task automatic test_gaps();
    logic pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 7; i++) begin
      drive(8'sd4, pat[i], 1'b0);
      if (i == 5) begin
        checks++;
        if (bus.fill_level !== '0) begin
          errors++;
          $display("FAIL gaps_early: fill_level=%0d expected 0", bus.fill_level);
        end
      end
    end
    idle(1, 1'b0);
    checks++;
    if (bus.fill_level !== 3'd1 || bus.out_data !== 8'sd4) begin
      errors++;
      $display("FAIL gaps_result: fill=%0d data=%0d expected fill 1 data 4",
               bus.fill_level, bus.out_data);
    end
    drain("gaps");
  endtask

  task automatic test_overflow();
    do_reset();
    for (int b = 0; b < 5; b++)
      repeat (NBLK) drive(DW'(b * 5 + 1), 1'b1, 1'b0);
    idle(1, 1'b0);
    checks++;
    if (bus.fill_level !== 3'd4 || bus.overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow_full: fill=%0d ovf=%b expected fill 4 ovf 1",
               bus.fill_level, bus.overflow);
    end
    drain("overflow");
    checks++;
    if (bus.overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow_sticky: overflow=%b expected 1", bus.overflow);
    end
  endtask

  task automatic test_full_push_pop();
    do_reset();
    for (int b = 0; b < 4; b++)
      repeat (NBLK) drive(DW'(b * 3 - 7), 1'b1, 1'b0);
    repeat (NBLK - 1) drive(8'sd40, 1'b1, 1'b0);
    checks++;
    if (bus.fill_level !== 3'd4) begin
      errors++;
      $display("FAIL pushpop_prefill: fill_level=%0d expected 4", bus.fill_level);
    end
    drive(8'sd40, 1'b1, 1'b1);
    idle(1, 1'b0);
    checks++;
    if (bus.fill_level !== 3'd4 || bus.overflow !== 1'b0) begin
      errors++;
      $display("FAIL pushpop_full: fill=%0d ovf=%b expected fill 4 ovf 0",
               bus.fill_level, bus.overflow);
    end
    drain("pushpop");
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++)
      drive(DW'($urandom_range(255)), ($urandom_range(9) < 7), ($urandom_range(9) < 3));
    drain("random");
    checks++;
    if (bus.overflow !== exp_ovf) begin
      errors++;
      $display("FAIL random_overflow: overflow=%b expected %b", bus.overflow, exp_ovf);
    end
  endtask

  initial begin
    bus.in_data   = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    rst_n         = 1'b0;
    model_reset();
    test_reset();
    test_average();
    test_gaps();
    test_overflow();
    test_full_push_pop();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end
endmodule
